ext_line_bridge: RTL

- Sits directly downstream of the memory-tile cache's external port; services its word-at-a-time tile loads and writes.
- Owns a single 16-word (64-byte) line buffer. A miss on a line triggers a sequential 16-word fill from the backing memory bus. Later words of that line are served with zero wait as they arrive.
- Writes are write-through to backing memory. They also update the line buffer on a hit.

---
 rtl/ext_line_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ext_line_bridge.sv
// Single-line (16 x 32b) read buffer between the tile cache's external port and backing memory.
// Optional watchdog on backing transfers is enabled with EXT_BRIDGE_TIMEOUT_EN.
module ext_line_bridge #(
    parameter int ADDR_W  = 48,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic              i_ext_oe,
    input  logic              i_ext_wr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_ext_data_oe,
    output logic              o_ext_not_ready,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_err
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:6] r_tag;
    logic [15:0]       r_word_valid;
    logic [DATA_W-1:0] r_buf [16];
    logic [3:0]        r_fill_idx;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        w_idx;
    logic              w_hit, w_rd, w_wr_hit, w_tmo;
    logic              w_unused;

    assign w_idx    = i_ext_addr[5:2];
    assign w_rd     = i_ext_oe && !i_ext_wr;
    assign w_hit    = (r_tag == i_ext_addr[ADDR_W-1:6]) && r_word_valid[w_idx];
    // Write-through data refreshes the buffer only if that word is already resident.
    assign w_wr_hit = (r_tag == r_mem_addr[ADDR_W-1:6]) && r_word_valid[r_mem_addr[5:2]];
    assign w_unused = ^i_ext_addr[1:0];

    assign o_ext_rdata   = r_buf[w_idx];
    assign o_ext_data_oe = w_rd;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;

    always_comb begin
        o_ext_not_ready = 1'b0;
        if (i_ext_wr)
            o_ext_not_ready = (r_state != WDONE);
        else if (i_ext_oe)
            o_ext_not_ready = !w_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_ext_wr) w_next = WRITE;
                     else if (i_ext_oe && !w_hit) w_next = FILL;
            FILL:    if (w_tmo || (i_mem_ack && r_fill_idx == 4'hF)) w_next = IDLE;
            WRITE:   if (w_tmo || i_mem_ack) w_next = WDONE;
            WDONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == IDLE && !i_ext_wr && i_ext_oe && !w_hit)
            r_tag <= i_ext_addr[ADDR_W-1:6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_valid <= '0;
            r_fill_idx   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_ext_wr) begin
                        r_mem_addr  <= {i_ext_addr[ADDR_W-1:2], 2'b00};
                        r_mem_wdata <= i_ext_wdata;
                        r_mem_we    <= 1'b1;
                        r_mem_req   <= 1'b1;
                    end else if (i_ext_oe && !w_hit) begin
                        r_word_valid <= '0;
                        r_fill_idx   <= '0;
                        r_mem_addr   <= {i_ext_addr[ADDR_W-1:6], 6'h00};
                        r_mem_we     <= 1'b0;
                        r_mem_req    <= 1'b1;
                    end
                end
                FILL: begin
                    if (w_tmo) begin
                        for (int i = 0; i < 16; i++)
                            if (!r_word_valid[i]) r_buf[i] <= DATA_W'(32'hDEAD_BEEF);
                        r_word_valid <= '1;
                        r_mem_req    <= 1'b0;
                    end else if (i_mem_ack) begin
                        r_buf[r_fill_idx]        <= i_mem_rdata;
                        r_word_valid[r_fill_idx] <= 1'b1;
                        if (r_fill_idx == 4'hF) begin
                            r_mem_req <= 1'b0;
                        end else begin
                            r_fill_idx      <= r_fill_idx + 4'd1;
                            r_mem_addr[5:2] <= r_fill_idx + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_wr_hit) r_buf[r_mem_addr[5:2]] <= r_mem_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EXT_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Counter sits at zero whenever no request is outstanding, so a new request starts from zero.
    assign w_tmo = r_mem_req && !i_mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_err = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!r_mem_req || i_mem_ack || w_tmo) r_cnt <= '0;
            else                                  r_cnt <= r_cnt + 1'b1;
            if (w_tmo) r_err <= 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT == 0);
    assign w_tmo        = 1'b0;
    assign o_err        = 1'b0;
`endif

endmodule
